// File: rtl/wb_ctrl_pkg.sv
// Shared constants for the writeback controller: enable levels, default widths, x0 address.
package wb_ctrl_pkg;
  localparam logic ENABLE     = 1'b1;
  localparam logic DISABLE    = 1'b0;
  localparam int   DATA_W_DEF = 32;
  localparam int   ADDR_W_DEF = 5;
  localparam int   DEPTH_DEF  = 4;
  localparam logic [ADDR_W_DEF-1:0] X0_ADDR = '0;
endpackage

// File: rtl/wb_fifo.sv
// Pending-result circular buffer: 0-2 pushes and 0-1 pop per cycle, entries exposed flat.
// Latency: a push is visible on the entry outputs the cycle after; caller guarantees no overflow.
module wb_fifo
  import wb_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push0,
  input  logic [ADDR_W-1:0]          push0_rd,
  input  logic [DATA_W-1:0]          push0_dat,
  input  logic                       push1,
  input  logic [ADDR_W-1:0]          push1_rd,
  input  logic [DATA_W-1:0]          push1_dat,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [$clog2(DEPTH)-1:0]   tail,
  output logic [DEPTH-1:0]           ent_vld,
  output logic [DEPTH*ADDR_W-1:0]    ent_rd,
  output logic [DEPTH*DATA_W-1:0]    ent_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] rd_q  [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     head_q, tail_q, tail1;
  logic [CW-1:0]     cnt_q;

  // the second push lands behind the first only if the first actually happened
  assign tail1 = tail_q + PW'(push0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (pop) begin
        vld_q[head_q] <= DISABLE;
        head_q        <= head_q + PW'(1);
      end
      if (push0) vld_q[tail_q] <= ENABLE;
      if (push1) vld_q[tail1]  <= ENABLE;
      tail_q <= tail_q + PW'(push0) + PW'(push1);
      cnt_q  <= cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push0) begin
      rd_q[tail_q]  <= push0_rd;
      dat_q[tail_q] <= push0_dat;
    end
    if (push1) begin
      rd_q[tail1]  <= push1_rd;
      dat_q[tail1] <= push1_dat;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign ent_rd[i*ADDR_W +: ADDR_W]  = rd_q[i];
    assign ent_dat[i*DATA_W +: DATA_W] = dat_q[i];
  end

  assign ent_vld = vld_q;
  assign cnt     = cnt_q;
  assign head    = head_q;
  assign tail    = tail_q;
endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: queues ALU/load results and commits one per cycle, forwarding pending values.
// Latency: accept at N, wren high after N+1; readies come from the registered count with no pop credit.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              wren,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] r_data,
  input  logic [ADDR_W-1:0] byp_addr1,
  input  logic [ADDR_W-1:0] byp_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2,
  output logic              busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     LIM1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0]     LIM2 = CW'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] X0   = ADDR_W'(X0_ADDR);

  logic [CW-1:0]          cnt;
  logic [PW-1:0]          head, tail;
  logic [DEPTH-1:0]       ent_vld;
  logic [DEPTH*ADDR_W-1:0] ent_rd;
  logic [DEPTH*DATA_W-1:0] ent_dat;
  logic                   push_mem, push_alu, pop;

  assign mem_ready = rst_n && (cnt <= LIM1);
  assign alu_ready = rst_n && (mem_valid ? (cnt <= LIM2) : (cnt <= LIM1));

  // x0 results complete the handshake but never occupy a slot
  assign push_mem = mem_valid && mem_ready && (mem_rd != X0);
  assign push_alu = alu_valid && alu_ready && (alu_rd != X0);
  assign pop      = (cnt != '0);

  wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push0     (push_mem),
    .push0_rd  (mem_rd),
    .push0_dat (mem_data),
    .push1     (push_alu),
    .push1_rd  (alu_rd),
    .push1_dat (alu_data),
    .pop       (pop),
    .cnt       (cnt),
    .head      (head),
    .tail      (tail),
    .ent_vld   (ent_vld),
    .ent_rd    (ent_rd),
    .ent_dat   (ent_dat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wren    <= DISABLE;
      rd_addr <= '0;
      r_data  <= '0;
    end else begin
      wren <= pop;
      if (pop) begin
        rd_addr <= ent_rd[head*ADDR_W +: ADDR_W];
        r_data  <= ent_dat[head*DATA_W +: DATA_W];
      end
    end
  end

  assign busy = pop || wren;

  // Output register is the oldest candidate; buffer slots are then scanned oldest to youngest
  // so the youngest match overrides everything before it.
  function automatic logic [DATA_W:0] byp_search(
    input logic [ADDR_W-1:0]       a,
    input logic [DEPTH-1:0]        vld,
    input logic [DEPTH*ADDR_W-1:0] rds,
    input logic [DEPTH*DATA_W-1:0] dats,
    input logic [PW-1:0]           tl,
    input logic                    wr,
    input logic [ADDR_W-1:0]       wa,
    input logic [DATA_W-1:0]       wd
  );
    logic [PW-1:0] idx;
    byp_search = '0;
    if (a != X0) begin
      if (wr && (wa == a)) byp_search = {ENABLE, wd};
      for (int i = DEPTH - 1; i >= 0; i--) begin
        idx = tl - PW'(i + 1);
        if (vld[idx] && (rds[idx*ADDR_W +: ADDR_W] == a))
          byp_search = {ENABLE, dats[idx*DATA_W +: DATA_W]};
      end
    end
  endfunction

  assign {byp_hit1, byp_data1} = byp_search(byp_addr1, ent_vld, ent_rd, ent_dat, tail, wren, rd_addr, r_data);
  assign {byp_hit2, byp_data2} = byp_search(byp_addr2, ent_vld, ent_rd, ent_dat, tail, wren, rd_addr, r_data);
endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios plus randomized traffic against a queue-based reference.
module tb_wb_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_valid = 1'b0, alu_valid = 1'b0;
  logic          mem_ready, alu_ready;
  logic [AW-1:0] mem_rd = '0, alu_rd = '0;
  logic [DW-1:0] mem_data = '0, alu_data = '0;
  logic          wren, busy;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] r_data;
  logic [AW-1:0] byp_addr1 = '0, byp_addr2 = '0;
  logic          byp_hit1, byp_hit2;
  logic [DW-1:0] byp_data1, byp_data2;

  wb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .wren(wren), .rd_addr(rd_addr), .r_data(r_data),
    .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] dat;
  } res_t;

  // reference: results waiting to be committed, plus what the write port shows now
  res_t          q[$];
  logic          m_wren = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit            mem_hold = 1'b0, alu_hold = 1'b0;
  int            n_chk = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_byp(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d = '0;
    if (a == 0) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].rd == a) begin
        hit = 1'b1;
        d = q[i].dat;
        return;
      end
    end
    if (m_wren && m_addr == a) begin
      hit = 1'b1;
      d = m_data;
    end
  endfunction

  // Called just after a negedge with inputs driven; checks all outputs, then advances one posedge.
  task automatic step();
    logic          exp_mr, exp_ar, h;
    logic [DW-1:0] d;
    bit            acc_m, acc_a;
    #1;
    exp_mr = rst_n && (q.size() <= DEPTH - 1);
    exp_ar = rst_n && (mem_valid ? (q.size() <= DEPTH - 2) : (q.size() <= DEPTH - 1));
    check_val("mem_ready", mem_ready, exp_mr);
    check_val("alu_ready", alu_ready, exp_ar);
    ref_byp(byp_addr1, h, d);
    check_val("byp_hit1", byp_hit1, h);
    check_val("byp_data1", byp_data1, d);
    ref_byp(byp_addr2, h, d);
    check_val("byp_hit2", byp_hit2, h);
    check_val("byp_data2", byp_data2, d);
    check_val("wren", wren, m_wren);
    check_val("rd_addr", rd_addr, m_addr);
    check_val("r_data", r_data, m_data);
    check_val("busy", busy, (q.size() != 0) || m_wren);
    acc_m = mem_valid && exp_mr;
    acc_a = alu_valid && exp_ar;
    mem_hold = mem_valid && !exp_mr;
    alu_hold = alu_valid && !exp_ar;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_wren = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      if (q.size() > 0) begin
        res_t r;
        r = q.pop_front();
        m_wren = 1'b1;
        m_addr = r.rd;
        m_data = r.dat;
      end else begin
        m_wren = 1'b0;
      end
      if (acc_m && mem_rd != 0) q.push_back({mem_rd, mem_data});
      if (acc_a && alu_rd != 0) q.push_back({alu_rd, alu_data});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pv;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("reset_wren", wren, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_mem_ready", mem_ready, 1);
    check_val("reset_alu_ready", alu_ready, 1);
    idle(2);

    // single ALU result x5
    byp_addr1 = 5;
    alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 1'b0;
    #1;
    check_val("x5_hit_n1", byp_hit1, 1);
    check_val("x5_wren_n1", wren, 0);
    step();
    check_val("x5_wren_n2", wren, 1);
    check_val("x5_addr_n2", rd_addr, 5);
    check_val("x5_data_n2", r_data, 32'hDEADBEEF);
    check_val("x5_hit_n2", byp_hit1, 1);
    step();
    check_val("x5_wren_n3", wren, 0);
    check_val("x5_hit_n3", byp_hit1, 0);
    idle(2);

    // simultaneous mem/ALU to x3: ALU is younger
    byp_addr1 = 3;
    mem_valid = 1'b1; mem_rd = 3; mem_data = 1;
    alu_valid = 1'b1; alu_rd = 3; alu_data = 2;
    step();
    mem_valid = 1'b0; alu_valid = 1'b0;
    #1;
    check_val("x3_byp_newest", byp_data1, 2);
    step();
    check_val("x3_first_write", r_data, 1);
    check_val("x3_byp_after_first", byp_data1, 2);
    step();
    check_val("x3_second_write", r_data, 2);
    idle(3);

    // x0 result: accepted, never written, never forwarded
    byp_addr1 = 0;
    mem_valid = 1'b1; mem_rd = 0; mem_data = 32'h1234;
    #1;
    check_val("x0_mem_ready", mem_ready, 1);
    step();
    mem_valid = 1'b0;
    step();
    check_val("x0_no_wren", wren, 0);
    idle(2);

    // fill to 3 pending, then reset
    mem_valid = 1'b1; mem_rd = 1; mem_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 2; alu_data = 32'h22;
    step();
    mem_rd = 4; mem_data = 32'h44;
    alu_rd = 6; alu_data = 32'h66;
    step();
    check_val("pend3_alu_ready", alu_ready, 0);
    mem_valid = 1'b0; alu_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_val("post_reset_wren", wren, 0);
    check_val("post_reset_busy", busy, 0);
    idle(2);

    // randomized traffic with payload held while stalled and occasional resets
    pv = 60;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) pv = $urandom_range(100, 20);
      if (!mem_hold) begin
        mem_valid = ($urandom_range(99) < pv);
        mem_rd    = AW'($urandom_range(7));
        mem_data  = $urandom;
      end
      if (!alu_hold) begin
        alu_valid = ($urandom_range(99) < pv);
        alu_rd    = AW'($urandom_range(7));
        alu_data  = $urandom;
      end
      byp_addr1 = AW'($urandom_range(7));
      byp_addr2 = AW'($urandom_range(7));
      rst_n = ($urandom_range(299) != 0);
      step();
    end
    rst_n = 1'b1;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
